// File: rtl/z_core_reg_file_mp.sv
// Multi-port register file: NUM_READ combinational reads, two write ports with optional bypass, and a pending-write scoreboard.
// Writes and scoreboard updates take effect at the rising edge. There is no backpressure; all ports are accepted every cycle.
module z_core_reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we0,
  input  logic [ADDR_WIDTH-1:0]          wa0,
  input  logic [DATA_WIDTH-1:0]          wd0,
  input  logic                           we1,
  input  logic [ADDR_WIDTH-1:0]          wa1,
  input  logic [DATA_WIDTH-1:0]          wd1,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rs_data,
  output logic [NUM_READ-1:0]            rs_busy,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  output logic [ADDR_WIDTH:0]            pending_cnt,
  output logic                           busy_any
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [CW-1:0]         cnt_nxt;
  logic                  wr0_ok, wr1_ok, iss_ok;
  logic                  set_new, clr0, clr1;

  // With ZERO_REG, register 0 is invisible to writes, issues and reads.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return !(ZERO_REG && (a == '0));
  endfunction

  assign wr0_ok = we0 && addr_ok(wa0);
  assign wr1_ok = we1 && addr_ok(wa1);
  assign iss_ok = issue_valid && addr_ok(issue_rd);

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr0_ok) regs[wa0] <= wd0;
      if (wr1_ok) regs[wa1] <= wd1;
    end
  end

  // Issue is applied after the clears so a new writer keeps ownership.
  always_comb begin
    busy_nxt = busy;
    if (wr0_ok) busy_nxt[wa0] = 1'b0;
    if (wr1_ok) busy_nxt[wa1] = 1'b0;
    if (iss_ok) busy_nxt[issue_rd] = 1'b1;
  end

  // Incremental count: each bit flip counted once, even when both ports hit one register.
  always_comb begin
    set_new = iss_ok && !busy[issue_rd];
    clr0    = wr0_ok && busy[wa0] && !(iss_ok && (issue_rd == wa0));
    clr1    = wr1_ok && busy[wa1] && !(iss_ok && (issue_rd == wa1))
              && !(wr0_ok && (wa0 == wa1));
    cnt_nxt = pending_cnt + CW'(set_new) - CW'(clr0) - CW'(clr1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      busy        <= busy_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

  assign busy_any = (pending_cnt != '0);

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic                  hit0, hit1;
    logic [DATA_WIDTH-1:0] d;

    assign a    = rs_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit0 = BYPASS && wr0_ok && (wa0 == a);
    assign hit1 = BYPASS && wr1_ok && (wa1 == a);

    always_comb begin
      d = regs[a];
      if (hit0) d = wd0;
      if (hit1) d = wd1;
      if (reset || !addr_ok(a)) d = '0;
    end

    assign rs_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
    assign rs_busy[i] = !reset && addr_ok(a) && busy[a] && !hit0 && !hit1;
  end

endmodule

// File: tb/tb_z_core_reg_file_mp.sv
// Bench for z_core_reg_file_mp: bypass and non-bypass instances share stimulus and one reference model.
module tb_z_core_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  logic we0, we1, issue_valid;
  logic [AW-1:0] wa0, wa1, issue_rd;
  logic [DW-1:0] wd0, wd1;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*DW-1:0] rd_b, rd_n;
  logic [NR-1:0] rb_b, rb_n;
  logic [AW:0] cnt_b, cnt_n;
  logic any_b, any_n;
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  z_core_reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .reset(reset), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rs_addr(rs_addr), .rs_data(rd_b), .rs_busy(rb_b), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .pending_cnt(cnt_b), .busy_any(any_b));

  z_core_reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_n (
    .clk(clk), .reset(reset), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rs_addr(rs_addr), .rs_data(rd_n), .rs_busy(rb_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .pending_cnt(cnt_n), .busy_any(any_n));

  // Reference model: plain arrays updated by the architectural rules.
  logic [DW-1:0] m_reg [DEPTH];
  bit m_busy [DEPTH];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we0 && wa0 != 0) m_reg[wa0] = wd0;
      if (we1 && wa1 != 0) m_reg[wa1] = wd1;
      if (we0) m_busy[wa0] = 1'b0;
      if (we1) m_busy[wa1] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_data(int p, bit byp);
    logic [AW-1:0] a;
    a = rs_addr[p*AW +: AW];
    if (reset || a == 0) return '0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(int p, bit byp);
    logic [AW-1:0] a;
    a = rs_addr[p*AW +: AW];
    if (reset || a == 0) return 1'b0;
    if (byp && ((we0 && wa0 == a) || (we1 && wa1 == a))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("rs_data_byp%0d", p), 64'(rd_b[p*DW +: DW]), 64'(exp_data(p, 1'b1)));
        chk($sformatf("rs_data_nobyp%0d", p), 64'(rd_n[p*DW +: DW]), 64'(exp_data(p, 1'b0)));
        chk($sformatf("rs_busy_byp%0d", p), 64'(rb_b[p]), 64'(exp_busy(p, 1'b1)));
        chk($sformatf("rs_busy_nobyp%0d", p), 64'(rb_n[p]), 64'(exp_busy(p, 1'b0)));
      end
      chk("pending_cnt_byp", 64'(cnt_b), 64'(exp_cnt()));
      chk("pending_cnt_nobyp", 64'(cnt_n), 64'(exp_cnt()));
      chk("busy_any", 64'(any_b), 64'(exp_cnt() != 0));
    end
  end

  task automatic idle();
    we0 = 0; we1 = 0; issue_valid = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; issue_rd = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rs_addr = '0;
    idle();
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_cnt", 64'(cnt_b), 64'd0);
    chk("reset_any", 64'(any_b), 64'd0);
    next();
    reset = 1'b0;

    // Basic writes through both ports, then read and swap.
    next(); we0 = 1; wa0 = 5; wd0 = 15;
    next(); idle(); we1 = 1; wa1 = 8; wd1 = 25;
    next(); idle(); rs_addr = {5'd8, 5'd5};
    @(negedge clk);
    chk("lit_rd0_15", 64'(rd_b[DW-1:0]), 64'd15);
    chk("lit_rd1_25", 64'(rd_b[2*DW-1:DW]), 64'd25);
    next(); rs_addr = {5'd5, 5'd8};
    @(negedge clk);
    chk("lit_swap_rd0", 64'(rd_b[DW-1:0]), 64'd25);
    chk("lit_swap_rd1", 64'(rd_b[2*DW-1:DW]), 64'd15);

    // Collision: port 1 wins.
    next(); we0 = 1; we1 = 1; wa0 = 12; wa1 = 12; wd0 = 32'hAAAA; wd1 = 32'h5555;
    next(); idle(); rs_addr = {5'd0, 5'd12};
    @(negedge clk);
    chk("lit_collision", 64'(rd_n[DW-1:0]), 64'h5555);

    // Disabled write and x0 protection.
    next(); wa0 = 10; wd0 = 30;
    next(); idle(); rs_addr = {5'd0, 5'd10};
    @(negedge clk);
    chk("lit_we0_off", 64'(rd_b[DW-1:0]), 64'd0);
    next(); we0 = 1; wa0 = 0; wd0 = 40; rs_addr = '0;
    @(negedge clk);
    chk("lit_x0_same", 64'(rd_b[DW-1:0]), 64'd0);
    next(); idle(); issue_valid = 1; issue_rd = 0;
    @(negedge clk);
    chk("lit_x0_read", 64'(rd_n[DW-1:0]), 64'd0);
    next(); idle();
    @(negedge clk);
    chk("lit_x0_issue", 64'(cnt_b), 64'd0);

    // Same-cycle bypass vs stored-only read.
    next(); we1 = 1; wa1 = 7; wd1 = 32'h1234; rs_addr = {5'd0, 5'd7};
    @(negedge clk);
    chk("lit_bypass_data", 64'(rd_b[DW-1:0]), 64'h1234);
    chk("lit_bypass_busy", 64'(rb_b[0]), 64'd0);
    chk("lit_nobypass_old", 64'(rd_n[DW-1:0]), 64'd0);
    next(); idle();
    @(negedge clk);
    chk("lit_nobypass_new", 64'(rd_n[DW-1:0]), 64'h1234);

    // Scoreboard.
    next(); issue_valid = 1; issue_rd = 3;
    next(); issue_rd = 4;
    next(); idle(); rs_addr = {5'd4, 5'd3};
    @(negedge clk);
    chk("lit_cnt2", 64'(cnt_b), 64'd2);
    chk("lit_any1", 64'(any_b), 64'd1);
    chk("lit_busy3", 64'(rb_b[0]), 64'd1);
    next(); we0 = 1; wa0 = 3; wd0 = 33; issue_valid = 1; issue_rd = 3;
    next(); idle();
    @(negedge clk);
    chk("lit_reissue_cnt", 64'(cnt_b), 64'd2);
    chk("lit_reissue_busy", 64'(rb_b[0]), 64'd1);
    next(); we0 = 1; wa0 = 3; wd0 = 34;
    next(); idle(); we0 = 1; wa0 = 4; wd0 = 44;
    next(); idle();
    @(negedge clk);
    chk("lit_cnt0", 64'(cnt_b), 64'd0);
    chk("lit_any0", 64'(any_b), 64'd0);

    // Async reset between edges.
    next(); issue_valid = 1; issue_rd = 1;
    next(); issue_rd = 2;
    next(); issue_rd = 5;
    next(); idle(); rs_addr = {5'd5, 5'd8};
    @(negedge clk);
    chk("lit_cnt3", 64'(cnt_b), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("lit_arst_data0", 64'(rd_b[DW-1:0]), 64'd0);
    chk("lit_arst_data1", 64'(rd_b[2*DW-1:DW]), 64'd0);
    chk("lit_arst_busy", 64'(rb_b), 64'd0);
    chk("lit_arst_cnt", 64'(cnt_b), 64'd0);
    #1 reset = 1'b0;
    next(); we0 = 1; wa0 = 9; wd0 = 77;
    next(); idle(); rs_addr = {5'd8, 5'd9};
    @(negedge clk);
    chk("lit_post_reset", 64'(rd_b[DW-1:0]), 64'd77);
    chk("lit_post_reset_old", 64'(rd_b[2*DW-1:DW]), 64'd0);

    // Random traffic on a narrowed address range to force collisions and hazards.
    for (int c = 0; c < 3000; c++) begin
      next();
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = AW'($urandom_range(0, 15));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, 15));
      wd0 = $urandom;
      wd1 = $urandom;
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd = ($urandom_range(0, 4) == 0) ? wa0 : AW'($urandom_range(0, 15));
      rs_addr = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    next(); idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
